// File: rtl/landing_scanner_pkg.sv
// landing_scanner_pkg: shared game definitions for the landing scanner.
// Holds the scan FSM state enum, the platform coordinate type (signed
// 11-bit x/y pair, element [0] = x left, element [1] = y top), the default
// playfield constants and small sign/zero extension helpers used by the
// 13-bit signed geometry.
package landing_scanner_pkg;

   localparam int N_PLATFORMS = 93;
   localparam int PLATFORM_W  = 64;
   localparam int DOODLE_W    = 48;
   localparam int DOODLE_H    = 48;
   localparam int TOL         = 8;
   localparam int FLOOR_Y     = 690;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } scan_state_t;

   // [0] = x left edge, [1] = y top edge, both signed 11-bit
   typedef logic signed [1:0][10:0] plat_coord_t;

   // sign-extend an 11-bit coordinate into the 13-bit compare domain
   function automatic logic signed [12:0] sext13(input logic [10:0] v);
      return $signed({{2{v[10]}}, v});
   endfunction

   // zero-extend the unsigned 10-bit doodle y into the 13-bit compare domain
   function automatic logic signed [12:0] zext13(input logic [9:0] v);
      return $signed({3'b000, v});
   endfunction

endpackage

// File: rtl/landing_scanner_hit_test.sv
// platform_hit_test: combinational landing test of the doodle hitbox against
// one platform slot.
// Ports:
//   doodle_x  in  signed 11  doodle hitbox left edge
//   doodle_y  in  10         doodle hitbox top edge
//   px, py    in  signed 11  platform left edge / top edge
//   hit       out 1          horizontal overlap and feet within [py, py+TOL]
// All arithmetic is done in 13-bit signed so negative x and y near 1023
// never wrap.
module platform_hit_test
   import landing_scanner_pkg::*;
#(
   parameter int PLATFORM_W = landing_scanner_pkg::PLATFORM_W,
   parameter int DOODLE_W   = landing_scanner_pkg::DOODLE_W,
   parameter int DOODLE_H   = landing_scanner_pkg::DOODLE_H,
   parameter int TOL        = landing_scanner_pkg::TOL
)
(
   input  logic signed [10:0] doodle_x,
   input  logic        [9:0]  doodle_y,
   input  logic signed [10:0] px,
   input  logic signed [10:0] py,
   output logic               hit
);

   localparam logic signed [12:0] PW13 = 13'(PLATFORM_W);
   localparam logic signed [12:0] DW13 = 13'(DOODLE_W);
   localparam logic signed [12:0] DH13 = 13'(DOODLE_H);
   localparam logic signed [12:0] TL13 = 13'(TOL);

   logic signed [12:0] dx_s;
   logic signed [12:0] px_s;
   logic signed [12:0] py_s;
   logic signed [12:0] feet_s;
   logic               x_ovl_s;
   logic               y_ovl_s;

   // geometric overlap: open interval in x, closed tolerance band in y
   always_comb begin
      dx_s    = sext13(doodle_x);
      px_s    = sext13(px);
      py_s    = sext13(py);
      feet_s  = zext13(doodle_y) + DH13;
      x_ovl_s = ((dx_s + DW13) > px_s) && (dx_s < (px_s + PW13));
      y_ovl_s = (py_s <= feet_s) && (feet_s <= (py_s + TL13));
      hit     = x_ovl_s && y_ovl_s;
   end

endmodule

// File: rtl/landing_scanner.sv
// landing_scanner: sequential scan of all platform slots for the doodle's
// landing surface, one slot per clock.
// Ports:
//   clk, rst (async, active-low), start (one-cycle scan request)
//   doodle_x/doodle_y/falling   doodle state, snapshotted on start
//   platforms/platform_activation  slot table, read live while scanning
//   busy      high in SCAN and DONE
//   done      one-cycle pulse when collision/ground/hit_index update
//   collision/ground/hit_index  landing result, held between done pulses
// The highest platform (smallest py) wins; ties go to the lower index because
// a later slot only replaces the best hit when strictly higher.
module landing_scanner
   import landing_scanner_pkg::*;
#(
   parameter int N_PLATFORMS = landing_scanner_pkg::N_PLATFORMS,
   parameter int PLATFORM_W  = landing_scanner_pkg::PLATFORM_W,
   parameter int DOODLE_W    = landing_scanner_pkg::DOODLE_W,
   parameter int DOODLE_H    = landing_scanner_pkg::DOODLE_H,
   parameter int TOL         = landing_scanner_pkg::TOL,
   parameter int FLOOR_Y     = landing_scanner_pkg::FLOOR_Y
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic signed [10:0]        doodle_x,
   input  logic        [9:0]         doodle_y,
   input  logic                      falling,
   input  plat_coord_t               platforms [N_PLATFORMS],
   input  logic [N_PLATFORMS-1:0]    platform_activation,
   output logic                      busy,
   output logic                      done,
   output logic                      collision,
   output logic [9:0]                ground,
   output logic [6:0]                hit_index
);

   localparam logic [6:0]         LAST_IDX = 7'(N_PLATFORMS - 1);
   localparam logic signed [12:0] FLOOR13  = 13'(FLOOR_Y);
   localparam logic [9:0]         FLOOR10  = 10'(FLOOR_Y);
   localparam logic signed [12:0] DH13     = 13'(DOODLE_H);

   scan_state_t        state_r, state_nxt;
   logic [6:0]         idx_r, idx_nxt;
   logic signed [10:0] dx_snap_r, dx_snap_nxt;
   logic [9:0]         dy_snap_r, dy_snap_nxt;
   logic               fall_snap_r, fall_snap_nxt;
   logic               best_found_r, best_found_nxt;
   logic signed [10:0] best_py_r, best_py_nxt;
   logic [6:0]         best_idx_r, best_idx_nxt;
   logic               busy_r, busy_nxt;
   logic               done_r, done_nxt;
   logic               collision_r, collision_nxt;
   logic [9:0]         ground_r, ground_nxt;
   logic [6:0]         hit_index_r, hit_index_nxt;

   logic               geo_hit_s;
   logic               slot_hit_s;
   logic signed [10:0] cur_py_s;
   logic signed [12:0] feet_s;

   platform_hit_test #(
      .PLATFORM_W (PLATFORM_W),
      .DOODLE_W   (DOODLE_W),
      .DOODLE_H   (DOODLE_H),
      .TOL        (TOL)
   ) u_hit (
      .doodle_x (dx_snap_r),
      .doodle_y (dy_snap_r),
      .px       (platforms[idx_r][0]),
      .py       (platforms[idx_r][1]),
      .hit      (geo_hit_s)
   );

   assign cur_py_s   = platforms[idx_r][1];
   assign slot_hit_s = geo_hit_s && platform_activation[idx_r] && fall_snap_r;
   assign feet_s     = zext13(dy_snap_r) + DH13;

   // next-state, best-hit tracking and result resolution
   always_comb begin
      state_nxt      = state_r;
      idx_nxt        = idx_r;
      dx_snap_nxt    = dx_snap_r;
      dy_snap_nxt    = dy_snap_r;
      fall_snap_nxt  = fall_snap_r;
      best_found_nxt = best_found_r;
      best_py_nxt    = best_py_r;
      best_idx_nxt   = best_idx_r;
      done_nxt       = 1'b0;
      collision_nxt  = collision_r;
      ground_nxt     = ground_r;
      hit_index_nxt  = hit_index_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               dx_snap_nxt    = doodle_x;
               dy_snap_nxt    = doodle_y;
               fall_snap_nxt  = falling;
               idx_nxt        = 7'd0;
               best_found_nxt = 1'b0;
               best_py_nxt    = 11'sd0;
               best_idx_nxt   = 7'd0;
               state_nxt      = ST_SCAN;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (slot_hit_s && (!best_found_r || (cur_py_s < best_py_r))) begin
               best_found_nxt = 1'b1;
               best_py_nxt    = cur_py_s;
               best_idx_nxt   = idx_r;
            end else begin
               best_found_nxt = best_found_r;
            end
            // last slot: publish the result together with the done pulse
            if (idx_r == LAST_IDX) begin
               state_nxt = ST_DONE;
               done_nxt  = 1'b1;
               if (best_found_nxt) begin
                  collision_nxt = 1'b1;
                  ground_nxt    = best_py_nxt[9:0];
                  hit_index_nxt = best_idx_nxt;
               end else if (feet_s >= FLOOR13) begin
                  collision_nxt = 1'b1;
                  ground_nxt    = FLOOR10;
                  hit_index_nxt = 7'd0;
               end else begin
                  collision_nxt = 1'b0;
                  ground_nxt    = FLOOR10;
                  hit_index_nxt = 7'd0;
               end
            end else begin
               idx_nxt = idx_r + 7'd1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
   end

   // state and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         idx_r        <= 7'd0;
         dx_snap_r    <= 11'sd0;
         dy_snap_r    <= 10'd0;
         fall_snap_r  <= 1'b0;
         best_found_r <= 1'b0;
         best_py_r    <= 11'sd0;
         best_idx_r   <= 7'd0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         collision_r  <= 1'b0;
         ground_r     <= FLOOR10;
         hit_index_r  <= 7'd0;
      end else begin
         state_r      <= state_nxt;
         idx_r        <= idx_nxt;
         dx_snap_r    <= dx_snap_nxt;
         dy_snap_r    <= dy_snap_nxt;
         fall_snap_r  <= fall_snap_nxt;
         best_found_r <= best_found_nxt;
         best_py_r    <= best_py_nxt;
         best_idx_r   <= best_idx_nxt;
         busy_r       <= busy_nxt;
         done_r       <= done_nxt;
         collision_r  <= collision_nxt;
         ground_r     <= ground_nxt;
         hit_index_r  <= hit_index_nxt;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign collision = collision_r;
   assign ground    = ground_r;
   assign hit_index = hit_index_r;

endmodule

// File: tb/tb_landing_scanner.sv
// tb_landing_scanner: table-driven, randomized and control-sequence checks of
// landing_scanner against a behavioural landing model.
module tb_landing_scanner;
   import landing_scanner_pkg::*;

   localparam int NP      = 93;
   localparam int PW      = 64;
   localparam int DW      = 48;
   localparam int DH      = 48;
   localparam int TL      = 8;
   localparam int FLOOR   = 690;
   localparam int LATENCY = NP + 1;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic signed [10:0] doodle_x;
   logic [9:0]         doodle_y;
   logic               falling;
   plat_coord_t        plats [NP];
   logic [NP-1:0]      act;
   logic               busy, done, collision;
   logic [9:0]         ground;
   logic [6:0]         hit_index;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;

   typedef struct {
      int dx; int dy; bit f;
      int ia; int xa; int ya; bit aa;
      int ib; int xb; int yb; bit ab;
      bit ecol; int egnd; int eidx;
   } vec_t;

   vec_t vecs [13];

   landing_scanner dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .doodle_x            (doodle_x),
      .doodle_y            (doodle_y),
      .falling             (falling),
      .platforms           (plats),
      .platform_activation (act),
      .busy                (busy),
      .done                (done),
      .collision           (collision),
      .ground              (ground),
      .hit_index           (hit_index)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string nm, input int actual, input int required);
      total++;
      if (actual != required) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, actual, required);
      end
   endtask

   // landing rule evaluated over the whole table at once
   task automatic model(input int dx, input int dy, input bit f,
                        output bit col, output int gnd, output int idx);
      int best;
      int best_py;
      int feet;
      best = -1; best_py = 0;
      feet = dy + DH;
      for (int i = 0; i < NP; i++) begin
         int px;
         int py;
         px = int'($signed(plats[i][0]));
         py = int'($signed(plats[i][1]));
         if (act[i] && f && (dx + DW > px) && (dx < px + PW) &&
             (py <= feet) && (feet <= py + TL)) begin
            if (best < 0 || py < best_py) begin
               best = i; best_py = py;
            end
         end
      end
      if (best >= 0) begin
         col = 1'b1; gnd = best_py & 1023; idx = best;
      end else begin
         col = (feet >= FLOOR); gnd = FLOOR; idx = 0;
      end
   endtask

   task automatic clear_plats();
      for (int i = 0; i < NP; i++) begin
         plats[i][0] = 11'($urandom);
         plats[i][1] = 11'($urandom);
         act[i]      = 1'b0;
      end
   endtask

   task automatic apply_vec(input vec_t v);
      clear_plats();
      if (v.ia >= 0) begin
         plats[v.ia][0] = 11'(v.xa); plats[v.ia][1] = 11'(v.ya); act[v.ia] = v.aa;
      end
      if (v.ib >= 0) begin
         plats[v.ib][0] = 11'(v.xb); plats[v.ib][1] = 11'(v.yb); act[v.ib] = v.ab;
      end
      doodle_x = 11'(v.dx); doodle_y = 10'(v.dy); falling = v.f;
   endtask

   // one scan; optionally re-pulses start at cycle pulse_at of the scan
   task automatic run_scan(input string nm, input int pulse_at, output int lat,
                           output bit col, output int gnd, output int idx);
      int c;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0; c = 1;
      chk({nm, " busy_in_scan"}, int'(busy), 1);
      while (done !== 1'b1 && c < 300) begin
         start = (c == pulse_at);
         @(posedge clk); #1; c++;
      end
      start = 1'b0;
      lat = c; col = collision; gnd = int'(ground); idx = int'(hit_index);
      @(posedge clk); #1;
      chk({nm, " done_width"}, int'(done), 0);
      chk({nm, " busy_idle"}, int'(busy), 0);
   endtask

   task automatic check_scan(input string nm, input int pulse_at,
                             input bit ecol, input int egnd, input int eidx);
      int lat, gnd, idx;
      bit col;
      run_scan(nm, pulse_at, lat, col, gnd, idx);
      chk({nm, " latency"}, lat, LATENCY);
      chk({nm, " collision"}, int'(col), int'(ecol));
      chk({nm, " ground"}, gnd, egnd);
      chk({nm, " hit_index"}, idx, eidx);
      repeat (4) @(posedge clk);
      #1;
      chk({nm, " hold_ground"}, int'(ground), egnd);
      chk({nm, " hold_hit_index"}, int'(hit_index), eidx);
   endtask

   initial begin
      bit  mcol;
      int  mg, mi, d0, c;

      vecs[0]  = '{120, 355, 1'b1,  5, 100,  400, 1'b1, -1, 0, 0, 1'b0, 1'b1,  400,  5};
      vecs[1]  = '{120, 362, 1'b1,  3, 100,  410, 1'b1,  7, 100, 405, 1'b1, 1'b1,  405,  7};
      vecs[2]  = '{120, 362, 1'b1,  3, 100,  405, 1'b1,  7, 100, 405, 1'b1, 1'b1,  405,  3};
      vecs[3]  = '{120, 355, 1'b0,  5, 100,  400, 1'b1, -1, 0, 0, 1'b0, 1'b0,  690,  0};
      vecs[4]  = '{120, 360, 1'b1,  5, 100,  400, 1'b1, -1, 0, 0, 1'b0, 1'b1,  400,  5};
      vecs[5]  = '{120, 361, 1'b1,  5, 100,  400, 1'b1, -1, 0, 0, 1'b0, 1'b0,  690,  0};
      vecs[6]  = '{  0, 252, 1'b1, 10, -40,  300, 1'b1, -1, 0, 0, 1'b0, 1'b1,  300, 10};
      vecs[7]  = '{120, 355, 1'b1,  5, 168,  400, 1'b1, -1, 0, 0, 1'b0, 1'b0,  690,  0};
      vecs[8]  = '{120, 650, 1'b1, -1,   0,    0, 1'b0, -1, 0, 0, 1'b0, 1'b1,  690,  0};
      vecs[9]  = '{120, 600, 1'b1, -1,   0,    0, 1'b0, -1, 0, 0, 1'b0, 1'b0,  690,  0};
      vecs[10] = '{120, 960, 1'b1,  0, 100, 1000, 1'b1, -1, 0, 0, 1'b0, 1'b1, 1000,  0};
      vecs[11] = '{210, 455, 1'b1, 92, 200,  500, 1'b1, -1, 0, 0, 1'b0, 1'b1,  500, 92};
      vecs[12] = '{120, 355, 1'b1,  5, 100,  400, 1'b0, -1, 0, 0, 1'b0, 1'b0,  690,  0};

      rst = 1'b0; start = 1'b0;
      apply_vec(vecs[0]);
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset collision", int'(collision), 0);
      chk("reset ground", int'(ground), FLOOR);
      chk("reset hit_index", int'(hit_index), 0);
      @(negedge clk); rst = 1'b1;

      // fixed vectors: DUT against the table, table against the model
      for (int k = 0; k < 13; k++) begin
         apply_vec(vecs[k]);
         model(vecs[k].dx, vecs[k].dy, vecs[k].f, mcol, mg, mi);
         chk($sformatf("vec%0d model_collision", k), int'(mcol), int'(vecs[k].ecol));
         chk($sformatf("vec%0d model_ground", k), mg, vecs[k].egnd);
         chk($sformatf("vec%0d model_index", k), mi, vecs[k].eidx);
         check_scan($sformatf("vec%0d", k), -1, vecs[k].ecol, vecs[k].egnd, vecs[k].eidx);
      end

      // randomized scans with platforms clustered around the doodle
      for (int r = 0; r < 30; r++) begin
         int dx, dy;
         dx = int'($urandom_range(0, 800)) - 200;
         dy = int'($urandom_range(0, 900));
         clear_plats();
         for (int i = 0; i < NP; i++) act[i] = 1'($urandom_range(0, 1));
         for (int k = 0; k < 6; k++) begin
            int s;
            s = int'($urandom_range(0, NP - 1));
            plats[s][0] = 11'(dx + int'($urandom_range(0, 140)) - 70);
            plats[s][1] = 11'(dy + DH - int'($urandom_range(0, 12)));
            act[s]      = 1'($urandom_range(0, 1));
         end
         doodle_x = 11'(dx); doodle_y = 10'(dy);
         falling  = ($urandom_range(0, 3) != 0);
         model(dx, dy, falling, mcol, mg, mi);
         check_scan($sformatf("rand%0d", r), -1, mcol, mg, mi);
      end

      // start re-pulsed at cycle 10 of a scan is dropped
      apply_vec(vecs[0]);
      d0 = done_cnt;
      check_scan("restart_ignored", 10, 1'b1, 400, 5);
      repeat (120) @(posedge clk);
      #1;
      chk("restart_single_done", done_cnt - d0, 1);

      // reset at cycle 40 of a scan
      apply_vec(vecs[1]);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0; c = 1;
      while (c < 40) begin
         @(posedge clk); #1; c++;
      end
      chk("midscan busy", int'(busy), 1);
      d0 = done_cnt;
      #2 rst = 1'b0;
      #1;
      chk("midreset busy", int'(busy), 0);
      chk("midreset done", int'(done), 0);
      chk("midreset collision", int'(collision), 0);
      chk("midreset ground", int'(ground), FLOOR);
      chk("midreset hit_index", int'(hit_index), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (120) @(posedge clk);
      #1;
      chk("midreset no_done", done_cnt - d0, 0);
      chk("midreset idle_collision", int'(collision), 0);
      check_scan("after_reset", -1, 1'b1, 405, 7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/landing_scanner.md
LANDING_SCANNER -- requirements
Module: landing_scanner

Interface
REQ-001 Parameter N_PLATFORMS, default 93; number of platform slots scanned.
REQ-002 Parameter PLATFORM_W, default 64; platform width in pixels.
REQ-003 Parameter DOODLE_W, default 48; doodle hitbox width in pixels.
REQ-004 Parameter DOODLE_H, default 48; doodle hitbox height in pixels.
REQ-005 Parameter TOL, default 8; landing tolerance in pixels below the platform top.
REQ-006 Parameter FLOOR_Y, default 690; ground value reported when no platform is hit.
REQ-007 clk  in  1  system clock; single clock domain.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 start  in  1  one-cycle request to begin a scan, typically the frame-sync edge.
REQ-010 doodle_x  in  11 signed  doodle hitbox left edge.
REQ-011 doodle_y  in  10  doodle hitbox top edge.
REQ-012 falling  in  1  doodle vertical velocity is downward.
REQ-013 platforms  in  N_PLATFORMS x 2 x 11 signed  per slot: [0]=x left, [1]=y top.
REQ-014 platform_activation  in  N_PLATFORMS  per-slot valid bit.
REQ-015 busy  out  1  scan in progress.
REQ-016 done  out  1  one-cycle pulse when results update.
REQ-017 collision  out  1  doodle landed on a platform or reached the floor; feeds the doodle collision input.
REQ-018 ground  out  10  y of the landing surface; feeds the doodle ground input.
REQ-019 hit_index  out  7  slot index of the chosen platform; 0 when no platform is hit.

Function
REQ-020 The FSM SHALL have three states, IDLE, SCAN and DONE, with IDLE as the reset state.
REQ-021 In IDLE, start=1 SHALL snapshot doodle_x, doodle_y and falling, clear index and the best-hit registers, and enter SCAN.
REQ-022 SCAN SHALL evaluate one slot per cycle, index 0..N_PLATFORMS-1, then enter DONE; total latency is start at cycle 0 and done=1 at cycle N_PLATFORMS+1.
REQ-023 Slot i SHALL be a hit when all of the following hold:
- platform_activation[i] is set, and the snapshotted falling is 1;
- doodle_x+DOODLE_W > px, and doodle_x < px+PLATFORM_W;
- feet = doodle_y+DOODLE_H satisfies py <= feet <= py+TOL.
REQ-024 All comparisons SHALL use 13-bit signed arithmetic; no wrap-around is permitted for negative px or for y values near 1023.
REQ-025 Among hits, the slot with the smallest py SHALL win; ties SHALL go to the lower index.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE, and outputs SHALL update on that cycle, resolved in this order:
- any hit: collision=1, ground=winner py[9:0], hit_index=winner;
- else feet >= FLOOR_Y: collision=1, ground=FLOOR_Y, hit_index=0;
- else: collision=0, ground=FLOOR_Y, hit_index=0.
REQ-027 collision, ground and hit_index SHALL hold their values between done pulses.
REQ-028 busy SHALL be 1 in SCAN and DONE, and 0 in IDLE.
REQ-029 start during SCAN or DONE SHALL be ignored and not queued.
REQ-030 platforms and platform_activation SHALL be sampled live during SCAN; the block does not snapshot them.

Reset
REQ-031 rst=0 SHALL immediately force the following, including mid-scan, with no done pulse:
- state to IDLE;
- busy=0, done=0, collision=0;
- ground=FLOOR_Y, hit_index=0;
- internal index and best-hit registers to 0.
REQ-032 The first start after reset deassertion SHALL behave as a normal scan.

Structure
REQ-033 A shared game package SHALL hold:
- the FSM state enum;
- the platform coordinate typedef (signed 11-bit x/y pair);
- constants N_PLATFORMS, FLOOR_Y and the doodle/platform dimensions.
REQ-034 The per-slot hit test SHALL be one combinational sub-module, platform_hit_test, with inputs doodle box and platform coordinates and a single hit output.

Verification
REQ-035 Single hit: slot 5 active at (100,400), doodle (120,355), falling=1, start -> done at cycle 94, collision=1, ground=400, hit_index=5.
REQ-036 Two hits: slots 3 (y=410) and 7 (y=405) both overlap, feet=410 -> hit_index=7, ground=405; with both at y=405 -> hit_index=3.
REQ-037 Rising: same setup as REQ-035 with falling=0 -> collision=0, ground=690.
REQ-038 Edge and negative coordinates, each checked separately:
- feet=py+8 -> hit; feet=py+9 -> no hit;
- platform x=-40 with doodle x=0 overlaps -> hit;
- doodle_x+48 == px -> no hit.
REQ-039 Floor: no active slots, doodle_y=650 (feet 698) -> collision=1, ground=690, hit_index=0; doodle_y=600 -> collision=0.
REQ-040 Control edge cases, each checked separately:
- start pulsed at cycle 10 of a scan -> ignored, exactly one done;
- rst=0 at cycle 40 -> outputs at reset values, no done;
- next start -> full 94-cycle scan.
